dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer for the shared data memory. Port 0 is the CPU load/store unit and port 1 is the loader/DMA engine. The block selects one request at a time, checks alignment, and drives a single registered memory command. It waits a fixed memory latency, then returns read data or a write acknowledge to the requester that won. It sits between the memory-stage logic / DMA engine and the data-memory array.

## Interface
- MEM_LATENCY, 1: cycles from command issue to valid `iMemRData`; legal range 1–15.
- ADDR_WIDTH, 32: address width.
- iClk  in  1  clock; all state updates on rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iReq0 / iReq1  in  1  access request; held stable until the matching grant.
- iWe0 / iWe1  in  1  1 = store, 0 = load.
- iSize0 / iSize1  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- iUnsigned0 / iUnsigned1  in  1  zero-extend loads.
- iAddr0 / iAddr1  in  ADDR_WIDTH  byte address.
- iWData0 / iWData1  in  32  store data.
- oGnt0 / oGnt1  out  1  one-cycle accept pulse; request fields are captured on this edge.
- oRValid0 / oRValid1  out  1  one-cycle completion pulse.
- oRData0 / oRData1  out  32  load data; 0 on stores and errors; holds its value between completions.
- oErr0 / oErr1  out  1  misaligned access; valid together with oRValid.
- oMemEn  out  1  one-cycle command strobe.
- oMemWe, oMemSize[1:0], oMemUnsigned, oMemAddr[ADDR_WIDTH-1:0], oMemWData[31:0]  out  registered command fields, stable from oMemEn until the response.
- iMemRData  in  32  memory read data, sampled MEM_LATENCY cycles after oMemEn.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, a combinational oGnt goes to the winner. On that edge the block latches the request fields and the owner id, then moves to ISSUE. With no request it stays in IDLE.
- Arbitration is round-robin: a 1-bit `last` pointer records the previous winner. On a simultaneous request the port other than `last` wins. `last` updates only on grant. Reset value of `last` is 1, so port 0 wins the first tie.
- Alignment check at grant:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]≠00 is misaligned.
- A misaligned request goes IDLE→RESP directly. It does not assert oMemEn and it produces oErr=1 with oRValid.
- ISSUE: oMemEn=1 for exactly one cycle, then WAIT. The counter loads MEM_LATENCY-1.
- WAIT: the counter decrements each cycle. When it reaches 0 the block captures iMemRData (loads only) into the owner's oRData, then moves to RESP.
- RESP: oRValid of the owner is 1 for one cycle, then IDLE. No grant is issued in RESP.
- Only one access is in flight at a time. Requests arriving during ISSUE, WAIT or RESP wait for IDLE.
- The memory performs byte/half extraction and extension; the arbiter forwards size and unsigned unchanged.
- Dropping iReq before grant is legal; the request is simply not served.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE, `last`=1, counter=0;
  - all oGnt, oRValid, oErr, oMemEn = 0;
  - oRData0/1=0 and all oMem* fields = 0.
- Aligned access with grant at edge N:
  - oMemEn is high in cycle N+1;
  - data is sampled at edge N+1+MEM_LATENCY;
  - oRValid is high in cycle N+2+MEM_LATENCY.
  - With MEM_LATENCY=1, that is grant-to-valid = 3 cycles, and back-to-back throughput is one access per 4 cycles.
- Misaligned access: oRValid+oErr high in cycle N+1.
- Reset asserted mid-access aborts the access immediately. No oRValid is produced and the pending data is discarded.
- Grant is combinational from iReq in IDLE. Requesters must not make iReq depend combinationally on oGnt.

## Configuration
- DMEM_ARB_CPU_PRIORITY_EN
  - Defined: fixed priority. Port 0 always wins a tie; `last` is unused and may be optimised away.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset mid-WAIT: iRstN low for 1 cycle while port 0 is in WAIT → all outputs 0 immediately; no oRValid0 after release; the next request is served normally.
- Single load, MEM_LATENCY=1: port 0 word load from 0x10004, memory returns 0xDEADBEEF → oGnt0 at cycle 0, oMemEn at cycle 1 with oMemAddr=0x10004, oRValid0 at cycle 3 with oRData0=0xDEADBEEF.
- Store: port 1 byte store of 0x000000A5 to 0x10003 → oMemWe=1, oMemSize=00, oMemWData=0x000000A5; oRValid1 with oRData1=0, oErr1=0.
- Round-robin tie: both ports request continuously for 4 accesses → grant order 0,1,0,1. With DMEM_ARB_CPU_PRIORITY_EN defined → grant order 0,0,0,0.
- Misaligned word load from 0x10002 on port 0 → no oMemEn, oRValid0=oErr0=1 one cycle after grant. A half access to 0x10002 completes with oErr0=0.
- Latency sweep: MEM_LATENCY=4, load returns 0x12345678 → oRValid asserted 6 cycles after grant with correct data; a request raised during WAIT is not granted until IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter and single-access sequencer
// Optional feature macro: DMEM_ARB_CPU_PRIORITY_EN (defined: port 0 always wins a tie;
// undefined: round-robin between the two ports).
// Ports:
//   iClk, iRstN                 clock, asynchronous active-low reset
//   iReq*/iWe*/iSize*/iUnsigned*/iAddr*/iWData*   request fields, port 0 = CPU LSU, port 1 = DMA
//   oGnt*                       combinational accept pulse (IDLE only)
//   oRValid*/oRData*/oErr*      registered completion, data and misalignment flag
//   oMemEn/oMemWe/oMemSize/oMemUnsigned/oMemAddr/oMemWData   registered memory command
//   iMemRData                   memory read data, sampled MEM_LATENCY cycles after oMemEn
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReq0,
    input  logic                  iReq1,
    input  logic                  iWe0,
    input  logic                  iWe1,
    input  logic [1:0]            iSize0,
    input  logic [1:0]            iSize1,
    input  logic                  iUnsigned0,
    input  logic                  iUnsigned1,
    input  logic [ADDR_WIDTH-1:0] iAddr0,
    input  logic [ADDR_WIDTH-1:0] iAddr1,
    input  logic [31:0]           iWData0,
    input  logic [31:0]           iWData1,
    output logic                  oGnt0,
    output logic                  oGnt1,
    output logic                  oRValid0,
    output logic                  oRValid1,
    output logic [31:0]           oRData0,
    output logic [31:0]           oRData1,
    output logic                  oErr0,
    output logic                  oErr1,
    output logic                  oMemEn,
    output logic                  oMemWe,
    output logic [1:0]            oMemSize,
    output logic                  oMemUnsigned,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [31:0]           oMemWData,
    input  logic [31:0]           iMemRData
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                state_q;
    logic                  owner_q;
    logic [3:0]            cnt_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic                  mem_uns_q;
    logic [1:0]            mem_size_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic                  err0_q;
    logic                  err1_q;
    logic [31:0]           rdata0_q;
    logic [31:0]           rdata1_q;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    logic                  last_q;
`endif

    logic                  gnt_any;
    logic                  pick1;
    logic                  sel_we;
    logic                  sel_uns;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  sel_misaligned;

    assign gnt_any = (state_q == IDLE) && (iReq0 || iReq1);

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    assign pick1 = ~iReq0;
`else
    // Port 1 wins when it is alone, or on a tie when port 0 won the previous grant.
    assign pick1 = iReq1 & (~iReq0 | ~last_q);
`endif

    assign oGnt0 = gnt_any & ~pick1;
    assign oGnt1 = gnt_any & pick1;

    always_comb begin
        sel_we    = pick1 ? iWe1       : iWe0;
        sel_uns   = pick1 ? iUnsigned1 : iUnsigned0;
        sel_size  = pick1 ? iSize1     : iSize0;
        sel_addr  = pick1 ? iAddr1     : iAddr0;
        sel_wdata = pick1 ? iWData1    : iWData0;
    end

    // Size 11 is treated as a word.
    always_comb begin
        sel_misaligned = 1'b0;
        case (sel_size)
            2'b01:        sel_misaligned = sel_addr[0];
            2'b10, 2'b11: sel_misaligned = |sel_addr[1:0];
            default:      sel_misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_uns_q   <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
            last_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        owner_q <= pick1;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
                        last_q  <= pick1;
`endif
                        if (sel_misaligned) begin
                            // Never reaches memory; complete with an error next cycle.
                            if (pick1) begin
                                rvalid1_q <= 1'b1;
                                err1_q    <= 1'b1;
                                rdata1_q  <= 32'd0;
                            end else begin
                                rvalid0_q <= 1'b1;
                                err0_q    <= 1'b1;
                                rdata0_q  <= 32'd0;
                            end
                            state_q <= RESP;
                        end else begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_uns_q   <= sel_uns;
                            mem_size_q  <= sel_size;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    cnt_q    <= LAT_LOAD;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        // Stores report zero data.
                        if (owner_q) begin
                            rdata1_q  <= mem_we_q ? 32'd0 : iMemRData;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= mem_we_q ? 32'd0 : iMemRData;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    err0_q    <= 1'b0;
                    err1_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oRValid0     = rvalid0_q;
    assign oRValid1     = rvalid1_q;
    assign oRData0      = rdata0_q;
    assign oRData1      = rdata1_q;
    assign oErr0        = err0_q;
    assign oErr1        = err1_q;
    assign oMemEn       = mem_en_q;
    assign oMemWe       = mem_we_q;
    assign oMemSize     = mem_size_q;
    assign oMemUnsigned = mem_uns_q;
    assign oMemAddr     = mem_addr_q;
    assign oMemWData    = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (latency 1 and latency 4 instances)
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    // ---------------- instance A: MEM_LATENCY = 1 ----------------
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, uns0 = 0, uns1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        mem_en, mem_we, mem_uns;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) u_dut_a (
        .iClk(clk), .iRstN(rst_n),
        .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
        .iSize0(size0), .iSize1(size1), .iUnsigned0(uns0), .iUnsigned1(uns1),
        .iAddr0(addr0), .iAddr1(addr1), .iWData0(wdata0), .iWData1(wdata1),
        .oGnt0(gnt0), .oGnt1(gnt1), .oRValid0(rv0), .oRValid1(rv1),
        .oRData0(rd0), .oRData1(rd1), .oErr0(err0), .oErr1(err1),
        .oMemEn(mem_en), .oMemWe(mem_we), .oMemSize(mem_size), .oMemUnsigned(mem_uns),
        .oMemAddr(mem_addr), .oMemWData(mem_wdata), .iMemRData(mem_rdata)
    );

    // ---------------- instance B: MEM_LATENCY = 4, loads only ----------------
    logic        b_req0 = 0, b_req1 = 0;
    logic [31:0] b_addr0 = 0, b_addr1 = 0;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_err0, b_err1;
    logic [31:0] b_rd0, b_rd1;
    logic        b_mem_en, b_mem_we, b_mem_uns;
    logic [1:0]  b_mem_size;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.MEM_LATENCY(4), .ADDR_WIDTH(32)) u_dut_b (
        .iClk(clk), .iRstN(rst_n),
        .iReq0(b_req0), .iReq1(b_req1), .iWe0(1'b0), .iWe1(1'b0),
        .iSize0(2'b10), .iSize1(2'b10), .iUnsigned0(1'b0), .iUnsigned1(1'b0),
        .iAddr0(b_addr0), .iAddr1(b_addr1), .iWData0(32'd0), .iWData1(32'd0),
        .oGnt0(b_gnt0), .oGnt1(b_gnt1), .oRValid0(b_rv0), .oRValid1(b_rv1),
        .oRData0(b_rd0), .oRData1(b_rd1), .oErr0(b_err0), .oErr1(b_err1),
        .oMemEn(b_mem_en), .oMemWe(b_mem_we), .oMemSize(b_mem_size), .oMemUnsigned(b_mem_uns),
        .oMemAddr(b_mem_addr), .oMemWData(b_mem_wdata), .iMemRData(b_mem_rdata)
    );

    // Bench memory contents.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0001_0004: return 32'hDEAD_BEEF;
            32'h0002_0000: return 32'h1234_5678;
            default:       return {a[15:0] ^ 16'h5A5A, a[15:0]};
        endcase
    endfunction

    // Memory models: read data is valid only in the cycle it must be sampled.
    logic [3:0]  a_lat = 4'd0;
    logic [31:0] a_pend = 32'd0;
    always @(posedge clk) begin
        if (mem_en) begin
            a_lat  <= 4'd1;
            a_pend <= mem_val(mem_addr);
        end else if (a_lat != 4'd0) begin
            a_lat <= a_lat - 4'd1;
        end
    end
    assign mem_rdata = (a_lat == 4'd1) ? a_pend : 32'hBAD0_BAD0;

    logic [3:0]  b_lat = 4'd0;
    logic [31:0] b_pend = 32'd0;
    always @(posedge clk) begin
        if (b_mem_en) begin
            b_lat  <= 4'd4;
            b_pend <= mem_val(b_mem_addr);
        end else if (b_lat != 4'd0) begin
            b_lat <= b_lat - 4'd1;
        end
    end
    assign b_mem_rdata = (b_lat == 4'd1) ? b_pend : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitors pop the scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (rv0 || rv1) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_rvalid", 64'({rv1, rv0}), 64'd0);
            end else begin
                e = sb_a.pop_front();
                chk("a_rvalid", 64'({rv1, rv0}), e.port ? 64'd2 : 64'd1);
                chk("a_rdata", 64'(e.port ? rd1 : rd0), 64'(e.data));
                chk("a_err", 64'({err1, err0}), e.err ? (e.port ? 64'd2 : 64'd1) : 64'd0);
                chk("a_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (err0 || err1) begin
            chk("a_err_without_rvalid", 64'({err1, err0}), 64'd0);
        end
        if (b_rv0 || b_rv1) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_rvalid", 64'({b_rv1, b_rv0}), 64'd0);
            end else begin
                e = sb_b.pop_front();
                chk("b_rvalid", 64'({b_rv1, b_rv0}), e.port ? 64'd2 : 64'd1);
                chk("b_rdata", 64'(e.port ? b_rd1 : b_rd0), 64'(e.data));
                chk("b_err", 64'({b_err1, b_err0}), 64'd0);
                chk("b_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drain_a();
        int t = 0;
        while (sb_a.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("a_drain", 64'(sb_a.size()), 64'd0);
        sb_a.delete();
    endtask

    task automatic drain_b();
        int t = 0;
        while (sb_b.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("b_drain", 64'(sb_b.size()), 64'd0);
        sb_b.delete();
    endtask

    // One access on instance A; checks the grant and the memory command, scoreboard checks completion.
    task automatic access_a(input bit port, input bit we, input logic [1:0] size, input bit uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input bit exp_err);
        exp_t e;
        int   t = 0;
        @(posedge clk); #1;
        if (!port) begin
            req0 = 1; we0 = we; size0 = size; uns0 = uns; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1; we1 = we; size1 = size; uns1 = uns; addr1 = addr; wdata1 = wdata;
        end
        @(negedge clk);
        while (!(port ? gnt1 : gnt0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("a_grant", 64'(port ? gnt1 : gnt0), 64'd1);
        chk("a_grant_excl", 64'(gnt0 & gnt1), 64'd0);
        e.port = port;
        e.err  = exp_err;
        e.data = (we || exp_err) ? 32'd0 : mem_val(addr);
        e.cyc  = exp_err ? cyc + 1 : cyc + 3;
        sb_a.push_back(e);
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("a_mem_en", 64'(mem_en), exp_err ? 64'd0 : 64'd1);
        if (!exp_err) begin
            chk("a_mem_addr", 64'(mem_addr), 64'(addr));
            chk("a_mem_we", 64'(mem_we), 64'(we));
            chk("a_mem_size", 64'(mem_size), 64'(size));
            chk("a_mem_uns", 64'(mem_uns), 64'(uns));
            chk("a_mem_wdata", 64'(mem_wdata), 64'(wdata));
        end
        drain_a();
    endtask

    initial begin
        exp_t e;
        int   t;
        int   g;
        int   nrv;
        bit   exp_order[4];
        bit   gp;

        // ---------------- reset values ----------------
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'({gnt1, gnt0}), 64'd0);
        chk("rst_rvalid", 64'({rv1, rv0}), 64'd0);
        chk("rst_err", 64'({err1, err0}), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_rdata", 64'({rd1, rd0}), 64'd0);
        chk("rst_mem_fields", 64'({mem_we, mem_size, mem_uns, mem_wdata}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // ---------------- tie: both ports request continuously ----------------
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        @(posedge clk); #1;
        we0 = 0; we1 = 0; size0 = 2'b10; size1 = 2'b10; uns0 = 0; uns1 = 0;
        addr0 = 32'h0001_0100; addr1 = 32'h0001_0200;
        req0 = 1; req1 = 1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            @(negedge clk);
            while (!(gnt0 || gnt1) && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("tie_grant_excl", 64'(gnt0 & gnt1), 64'd0);
            chk("tie_order", 64'(gnt1), 64'(exp_order[k]));
            gp     = gnt1;
            e.port = gp;
            e.err  = 0;
            e.data = mem_val(gp ? addr1 : addr0);
            e.cyc  = cyc + 3;
            sb_a.push_back(e);
            @(posedge clk); #1;
            if (k == 3) begin
                req0 = 0; req1 = 0;
            end else if (gp) begin
                addr1 = addr1 + 32'd4;
            end else begin
                addr0 = addr0 + 32'd4;
            end
        end
        drain_a();

        // ---------------- single accesses on latency-1 instance ----------------
        access_a(0, 0, 2'b10, 0, 32'h0001_0004, 32'd0, 0);          // word load -> DEADBEEF
        access_a(1, 1, 2'b00, 0, 32'h0001_0003, 32'h0000_00A5, 0);  // byte store
        access_a(0, 0, 2'b10, 0, 32'h0001_0002, 32'd0, 1);          // misaligned word
        access_a(1, 0, 2'b01, 0, 32'h0001_0005, 32'd0, 1);          // misaligned half
        access_a(0, 0, 2'b11, 0, 32'h0001_0001, 32'd0, 1);          // size 11 is a word
        access_a(0, 0, 2'b01, 1, 32'h0001_0002, 32'd0, 0);          // aligned half, unsigned
        repeat (3) @(negedge clk);
        chk("rdata0_hold", 64'(rd0), 64'(mem_val(32'h0001_0002)));

        // ---------------- reset in the middle of WAIT ----------------
        @(posedge clk); #1;
        req0 = 1; we0 = 0; size0 = 2'b10; addr0 = 32'h0001_0008;
        t = 0;
        @(negedge clk);
        while (!gnt0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_grant", 64'(gnt0), 64'd1);
        @(posedge clk); #1;
        req0 = 0;                 // ISSUE
        @(posedge clk); #1;       // WAIT
        rst_n = 0;
        #1;
        chk("rstmid_mem_en", 64'(mem_en), 64'd0);
        chk("rstmid_mem_addr", 64'(mem_addr), 64'd0);
        chk("rstmid_rdata0", 64'(rd0), 64'd0);
        chk("rstmid_rvalid", 64'({rv1, rv0}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        nrv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rv0) nrv++;
        end
        chk("rstmid_no_rvalid", 64'(nrv), 64'd0);
        access_a(0, 0, 2'b10, 0, 32'h0001_0004, 32'd0, 0);

        // ---------------- latency 4 instance ----------------
        @(posedge clk); #1;
        b_req0 = 1; b_addr0 = 32'h0002_0000;
        t = 0;
        @(negedge clk);
        while (!b_gnt0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b_grant0", 64'(b_gnt0), 64'd1);
        g      = cyc;
        e.port = 0; e.err = 0; e.data = 32'h1234_5678; e.cyc = g + 6;
        sb_b.push_back(e);
        @(posedge clk); #1;
        b_req0 = 0;
        @(negedge clk);
        chk("b_mem_en", 64'(b_mem_en), 64'd1);
        @(posedge clk); #1;       // access is in WAIT
        b_req1 = 1; b_addr1 = 32'h0002_0040;
        t = 0;
        @(negedge clk);
        while (!b_gnt1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b_grant1_after_idle", 64'(cyc), 64'(g + 7));
        e.port = 1; e.err = 0; e.data = mem_val(32'h0002_0040); e.cyc = cyc + 6;
        sb_b.push_back(e);
        @(posedge clk); #1;
        b_req1 = 0;
        drain_b();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
